// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the boot loader.
// The master side feeds the image; the slave side is the loader.
interface imem_loader_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) ();
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     reload;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     cpu_rst;
  logic                     done;
  logic                     err;

  modport master (
    output byte_valid, byte_data, reload,
    input  byte_ready, we, waddr, wdata, cpu_rst, done, err
  );

  modport slave (
    input  byte_valid, byte_data, reload,
    output byte_ready, we, waddr, wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream
// (word-count header followed by words) into RAM writes, holding the CPU in reset.
module imem_loader #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC0_0000,
  parameter int unsigned              MAX_WORDS     = 1024
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {LEN = 2'd0, DATA = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(3'd4);

  state_t                   state_r, state_next_s;
  logic [1:0]               byte_cnt_r, byte_cnt_next_s;
  logic [31:0]              shift_r, shift_next_s;
  logic [31:0]              word_cnt_r, word_cnt_next_s;
  logic [31:0]              written_r, written_next_s;
  logic [ADDRESS_WIDTH-1:0] next_addr_r, next_addr_next_s;
  logic                     we_r, we_next_s;
  logic [ADDRESS_WIDTH-1:0] waddr_r, waddr_next_s;
  logic [DATA_WIDTH-1:0]    wdata_r, wdata_next_s;
  logic                     cpu_rst_r, done_r, err_r;
  logic                     done_next_s;
  logic                     accept_s;
  logic [31:0]              assembled_s;

  assign bus.byte_ready = (state_r == LEN) || (state_r == DATA);
  assign accept_s       = bus.byte_valid && bus.byte_ready;
  // First byte of a word lands in bits [7:0] after four shifts.
  assign assembled_s    = {bus.byte_data, shift_r[31:8]};

  // Next-state and next-output decode
  always_comb begin
    state_next_s     = state_r;
    byte_cnt_next_s  = byte_cnt_r;
    shift_next_s     = shift_r;
    word_cnt_next_s  = word_cnt_r;
    written_next_s   = written_r;
    next_addr_next_s = next_addr_r;
    we_next_s        = 1'b0;
    waddr_next_s     = waddr_r;
    wdata_next_s     = wdata_r;
    case (state_r)
      LEN: begin
        if (accept_s) begin
          shift_next_s    = assembled_s;
          byte_cnt_next_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            word_cnt_next_s = assembled_s;
            if (assembled_s == 32'd0) begin
              state_next_s = DONE;
            end else if (assembled_s > 32'(MAX_WORDS)) begin
              state_next_s = ERR;
            end else begin
              state_next_s = DATA;
            end
          end else begin
            state_next_s = LEN;
          end
        end else begin
          state_next_s = LEN;
        end
      end
      DATA: begin
        if (accept_s) begin
          shift_next_s    = assembled_s;
          byte_cnt_next_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            we_next_s        = 1'b1;
            wdata_next_s     = assembled_s;
            waddr_next_s     = next_addr_r;
            next_addr_next_s = next_addr_r + ADDR_STEP;
            written_next_s   = written_r + 32'd1;
            // The final write's we cycle is spent in DONE with done still low.
            if ((written_r + 32'd1) == word_cnt_r) begin
              state_next_s = DONE;
            end else begin
              state_next_s = DATA;
            end
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      DONE, ERR: begin
        if (bus.reload) begin
          state_next_s     = LEN;
          byte_cnt_next_s  = 2'd0;
          shift_next_s     = 32'd0;
          word_cnt_next_s  = 32'd0;
          written_next_s   = 32'd0;
          next_addr_next_s = BASE_ADDR;
          waddr_next_s     = BASE_ADDR;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = LEN;
      end
    endcase
  end

  assign done_next_s = (state_next_s == DONE) && !we_next_s;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LEN;
      byte_cnt_r  <= 2'd0;
      shift_r     <= 32'd0;
      word_cnt_r  <= 32'd0;
      written_r   <= 32'd0;
      next_addr_r <= BASE_ADDR;
      we_r        <= 1'b0;
      waddr_r     <= BASE_ADDR;
      wdata_r     <= '0;
      cpu_rst_r   <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      byte_cnt_r  <= byte_cnt_next_s;
      shift_r     <= shift_next_s;
      word_cnt_r  <= word_cnt_next_s;
      written_r   <= written_next_s;
      next_addr_r <= next_addr_next_s;
      we_r        <= we_next_s;
      waddr_r     <= waddr_next_s;
      wdata_r     <= wdata_next_s;
      cpu_rst_r   <= !done_next_s;
      done_r      <= done_next_s;
      err_r       <= (state_next_s == ERR);
    end
  end

  assign bus.we      = we_r;
  assign bus.waddr   = waddr_r;
  assign bus.wdata   = wdata_r;
  assign bus.cpu_rst = cpu_rst_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table plus hand sequences
// for async reset mid-load, stream gaps and back-to-back word throughput.
module tb_imem_loader;
  localparam logic [31:0] B0 = 32'hBFC0_0000;
  localparam logic [31:0] B4 = 32'hBFC0_0004;

  logic clk;
  logic rst_n;
  imem_loader_if bus ();

  imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        crst;
    logic        rdy;
  } vec_t;

  vec_t        vq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  logic [31:0] img[0:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: record every we pulse with its cycle
  always @(posedge clk) begin
    #1;
    if (bus.we === 1'b1) begin
      q_addr.push_back(bus.waddr);
      q_data.push_back(bus.wdata);
      q_cyc.push_back(cyc);
    end
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic rl,
                     input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic dn, input logic er, input logic cr, input logic rd);
    vec_t t;
    t.v = v; t.d = d; t.rl = rl; t.we = we; t.waddr = wa; t.wdata = wd;
    t.done = dn; t.err = er; t.crst = cr; t.rdy = rd;
    vq.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
        step();
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
  endtask

  task automatic run_image(input int n, input bit gaps, input string tag);
    logic [31:0] hdr;
    int          k;
    hdr = 32'(n);
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    for (int b = 0; b < 4; b++) send_byte(hdr[8*b +: 8], gaps);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], gaps);
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " cpu_rst"}, 64'(bus.cpu_rst), 64'd0);
    check({tag, " wcount"}, 64'(q_addr.size()), 64'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      check($sformatf("%s waddr%0d", tag, i), 64'(q_addr[i]), 64'(B0 + 32'(4 * i)));
      check($sformatf("%s wdata%0d", tag, i), 64'(q_data[i]), 64'(img[i]));
      if (!gaps && i > 0)
        check($sformatf("%s spacing%0d", tag, i), 64'(q_cyc[i] - q_cyc[i-1]), 64'd4);
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.reload     = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst we", 64'(bus.we), 64'd0);
    check("rst waddr", 64'(bus.waddr), 64'(B0));
    check("rst wdata", 64'(bus.wdata), 64'd0);
    check("rst cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst err", 64'(bus.err), 64'd0);
    check("rst ready", 64'(bus.byte_ready), 64'd1);
    rst_n = 1'b1;

    // Two-word image, then bytes ignored in DONE
    add(1'b1, 8'h02, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h13, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h05, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h50, 1'b0, 1'b0, B0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b1, B0, 32'h00500513, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h93, 1'b0, 1'b0, B0, 32'h00500513, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h05, 1'b0, 1'b0, B0, 32'h00500513, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'hA0, 1'b0, 1'b0, B0, 32'h00500513, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b1, B4, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, B4, 32'h00A00593, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 1'b0, B4, 32'h00A00593, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h13, 1'b0, 1'b0, B4, 32'h00A00593, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reload, single-word image
    add(1'b0, 8'h00, 1'b1, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h01, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h11, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h22, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h33, 1'b0, 1'b0, B0, 32'h00A00593, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h44, 1'b0, 1'b1, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reload, zero-length image goes straight to DONE
    add(1'b0, 8'h00, 1'b1, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reload, N = MAX_WORDS+1 -> ERR, bytes ignored, reload recovers
    add(1'b0, 8'h00, 1'b1, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h01, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h04, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 8'hAA, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    // N = MAX_WORDS exactly is accepted; reload in DATA is ignored
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h04, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 8'h00, 1'b0, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, B0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      bus.byte_valid = vq[i].v;
      bus.byte_data  = vq[i].d;
      bus.reload     = vq[i].rl;
      step();
      check($sformatf("vec%0d we", i), 64'(bus.we), 64'(vq[i].we));
      check($sformatf("vec%0d waddr", i), 64'(bus.waddr), 64'(vq[i].waddr));
      check($sformatf("vec%0d wdata", i), 64'(bus.wdata), 64'(vq[i].wdata));
      check($sformatf("vec%0d done", i), 64'(bus.done), 64'(vq[i].done));
      check($sformatf("vec%0d err", i), 64'(bus.err), 64'(vq[i].err));
      check($sformatf("vec%0d cpu_rst", i), 64'(bus.cpu_rst), 64'(vq[i].crst));
      check($sformatf("vec%0d ready", i), 64'(bus.byte_ready), 64'(vq[i].rdy));
    end
    bus.byte_valid = 1'b0;
    bus.reload     = 1'b0;

    // Async reset two bytes into a word: no write, outputs back to reset values
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst we", 64'(bus.we), 64'd0);
    check("arst waddr", 64'(bus.waddr), 64'(B0));
    check("arst wdata", 64'(bus.wdata), 64'd0);
    check("arst cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check("arst done", 64'(bus.done), 64'd0);
    check("arst ready", 64'(bus.byte_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("arst no write", 64'(q_addr.size()), 64'd0);

    img[0] = 32'h00500513; img[1] = 32'h00A00593;
    run_image(2, 1'b0, "after_rst");

    img[0] = 32'h11223344; img[1] = 32'hDEADBEEF; img[2] = 32'h00000013;
    pulse_reload();
    run_image(3, 1'b1, "gaps");
    pulse_reload();
    run_image(3, 1'b0, "nogaps");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
